ble_scan_ctrl: RTL

BLE_SCAN_CTRL -- requirements
Module: ble_scan_ctrl

---
 rtl/ble_rx_pkg.sv | 49 ++++
 rtl/ble_chan_sel.sv | 48 ++++
 rtl/ble_scan_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ble_rx_pkg.sv
// Shared BLE receive definitions: FSM state encodings, advertising channel
// codes and small channel helpers used by the scan controller and its
// channel selector.
package ble_rx_pkg;

  localparam int unsigned ST_W = 3;
  localparam int unsigned CH_W = 2;
  localparam int unsigned NUM_ADV_CH = 3;

  typedef logic [ST_W-1:0] state_t;
  typedef logic [CH_W-1:0] chan_t;

  // Scan FSM state encodings (also exported on the state port)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_LISTEN = 3'd2;
  localparam logic [2:0] ST_LOCKED = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;
  localparam logic [2:0] ST_HOP    = 3'd5;

  // Advertising channel codes driven to the CDR core
  localparam logic [1:0] CH37 = 2'b00;
  localparam logic [1:0] CH38 = 2'b01;
  localparam logic [1:0] CH39 = 2'b10;

  // Next channel in hop order 37 -> 38 -> 39 -> 37
  function automatic chan_t chan_inc(input chan_t ch);
    chan_t r;
    case (ch)
      CH37:    r = CH38;
      CH38:    r = CH39;
      default: r = CH37;
    endcase
    return r;
  endfunction

  // One-hot mask bit corresponding to a channel code (bit0 = channel 37)
  function automatic logic [NUM_ADV_CH-1:0] chan_oh(input chan_t ch);
    logic [NUM_ADV_CH-1:0] r;
    case (ch)
      CH37:    r = 3'b001;
      CH38:    r = 3'b010;
      CH39:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ble_chan_sel.sv
// Combinational advertising-channel picker.
// Ports:
//   cur_chan     - channel currently selected
//   chan_mask    - channel enables (bit0=37, bit1=38, bit2=39)
//   first_chan_c - lowest enabled channel (used when a scan starts)
//   next_chan_c  - next enabled channel after cur_chan, wrapping, falling back
//                  to cur_chan when it is the only one enabled
//   none_c       - no channel enabled
module ble_chan_sel
  import ble_rx_pkg::*;
(
  input  logic [1:0] cur_chan,
  input  logic [2:0] chan_mask,
  output logic [1:0] first_chan_c,
  output logic [1:0] next_chan_c,
  output logic       none_c
);

  logic [1:0] cand1;
  logic [1:0] cand2;

  // Lowest enabled channel
  always_comb begin
    first_chan_c = CH37;
    none_c       = (chan_mask == 3'b000);
    if (chan_mask[0]) begin
      first_chan_c = CH37;
    end else if (chan_mask[1]) begin
      first_chan_c = CH38;
    end else if (chan_mask[2]) begin
      first_chan_c = CH39;
    end
  end

  // Hop candidates in wrap order; the nearest enabled one wins
  always_comb begin
    cand1       = chan_inc(cur_chan);
    cand2       = chan_inc(cand1);
    next_chan_c = cur_chan;
    if ((chan_mask & chan_oh(cand2)) != 3'b000) begin
      next_chan_c = cand2;
    end
    if ((chan_mask & chan_oh(cand1)) != 3'b000) begin
      next_chan_c = cand1;
    end
  end

endmodule

// File: rtl/ble_scan_ctrl.sv
// BLE advertising-channel scan controller. Cycles the CDR core over the
// enabled advertising channels: flush (SETTLE), listen for a dwell period,
// follow a detected preamble (LOCKED) and report received packets.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   start, stop            - one-cycle pulses to begin / abort scanning
//   chan_mask              - channel enables, bit0 = 37
//   dwell_len              - LISTEN cycles per channel (0 behaves as 1)
//   lock_timeout           - LOCKED cycles before abandoning (0 behaves as 1)
//   preamble_det           - level status from the CDR core
//   packet_det             - level status from the CDR core
//   channel_sel            - channel code to the core
//   core_en, core_rst_n    - core enable and active-low flush
//   pkt_valid, pkt_chan    - per-packet pulse and its channel
//   pkt_count              - saturating packet counter
//   busy, cfg_err, state   - status
module ble_scan_ctrl
  import ble_rx_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned PKT_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [2:0]           chan_mask,
  input  logic [CNT_W-1:0]     dwell_len,
  input  logic [CNT_W-1:0]     lock_timeout,
  input  logic                 preamble_det,
  input  logic                 packet_det,
  output logic [1:0]           channel_sel,
  output logic                 core_en,
  output logic                 core_rst_n,
  output logic                 pkt_valid,
  output logic [1:0]           pkt_chan,
  output logic [PKT_CNT_W-1:0] pkt_count,
  output logic                 busy,
  output logic                 cfg_err,
  output logic [2:0]           state
);

  localparam int unsigned SET_W    = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned SET_LAST = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;

  logic [2:0]           state_q,       state_d;
  logic [1:0]           channel_sel_q, channel_sel_d;
  logic [SET_W-1:0]     settle_cnt_q,  settle_cnt_d;
  logic [CNT_W-1:0]     tmr_q,         tmr_d;
  logic                 pre_q,         pre_d;
  logic                 pkt_q,         pkt_d;
  logic                 core_en_q,     core_en_d;
  logic                 core_rst_n_q,  core_rst_n_d;
  logic                 pkt_valid_q,   pkt_valid_d;
  logic [1:0]           pkt_chan_q,    pkt_chan_d;
  logic [PKT_CNT_W-1:0] pkt_count_q,   pkt_count_d;
  logic                 busy_q,        busy_d;
  logic                 cfg_err_q,     cfg_err_d;

  logic [1:0]       first_chan_c;
  logic [1:0]       next_chan_c;
  logic             none_c;
  logic             pre_rise_c;
  logic             pkt_rise_c;
  logic [CNT_W-1:0] dwell_last_c;
  logic [CNT_W-1:0] lock_last_c;

  ble_chan_sel u_chan_sel (
    .cur_chan     (channel_sel_q),
    .chan_mask    (chan_mask),
    .first_chan_c (first_chan_c),
    .next_chan_c  (next_chan_c),
    .none_c       (none_c)
  );

  // Edge detect against the previous cycle; the history register runs in
  // every state so a level already high when SETTLE ends is not an edge.
  assign pre_rise_c = preamble_det & ~pre_q;
  assign pkt_rise_c = packet_det & ~pkt_q;

  // Terminal timer values with zero lengths behaving as one cycle
  assign dwell_last_c = (dwell_len == '0) ? '0 : dwell_len - CNT_W'(1);
  assign lock_last_c  = (lock_timeout == '0) ? '0 : lock_timeout - CNT_W'(1);

  // Next-state and registered-output decode
  always_comb begin
    state_d       = state_q;
    channel_sel_d = channel_sel_q;
    settle_cnt_d  = settle_cnt_q;
    tmr_d         = tmr_q;
    cfg_err_d     = cfg_err_q;
    pre_d         = preamble_det;
    pkt_d         = packet_det;
    pkt_chan_d    = pkt_chan_q;
    pkt_count_d   = pkt_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (none_c) begin
            cfg_err_d = 1'b1;
          end else begin
            cfg_err_d     = 1'b0;
            channel_sel_d = first_chan_c;
            settle_cnt_d  = '0;
            state_d       = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SET_W'(SET_LAST)) begin
          tmr_d   = '0;
          state_d = ST_LISTEN;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      ST_LISTEN: begin
        if (pkt_rise_c) begin
          state_d = ST_REPORT;
        end else if (pre_rise_c) begin
          tmr_d   = '0;
          state_d = ST_LOCKED;
        end else if (tmr_q == dwell_last_c) begin
          state_d = ST_HOP;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (pkt_rise_c) begin
          state_d = ST_REPORT;
        end else if (tmr_q == lock_last_c) begin
          state_d = ST_HOP;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      ST_REPORT: begin
        state_d = ST_HOP;
      end
      ST_HOP: begin
        if (none_c) begin
          cfg_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          channel_sel_d = next_chan_c;
          settle_cnt_d  = '0;
          state_d       = ST_SETTLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides every other event; the channel and error flag hold
    if (stop && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      channel_sel_d = channel_sel_q;
      cfg_err_d     = cfg_err_q;
    end

    // Outputs follow the state being entered so they line up with state_q
    core_en_d    = (state_d == ST_LISTEN) || (state_d == ST_LOCKED) ||
                   (state_d == ST_REPORT);
    core_rst_n_d = (state_d != ST_IDLE) && (state_d != ST_SETTLE);
    busy_d       = (state_d != ST_IDLE);
    pkt_valid_d  = (state_d == ST_REPORT);
    if (state_d == ST_REPORT) begin
      pkt_chan_d = channel_sel_q;
      if (!(&pkt_count_q)) begin
        pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      channel_sel_q <= CH37;
      settle_cnt_q  <= '0;
      tmr_q         <= '0;
      pre_q         <= 1'b0;
      pkt_q         <= 1'b0;
      core_en_q     <= 1'b0;
      core_rst_n_q  <= 1'b0;
      pkt_valid_q   <= 1'b0;
      pkt_chan_q    <= CH37;
      pkt_count_q   <= '0;
      busy_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      channel_sel_q <= channel_sel_d;
      settle_cnt_q  <= settle_cnt_d;
      tmr_q         <= tmr_d;
      pre_q         <= pre_d;
      pkt_q         <= pkt_d;
      core_en_q     <= core_en_d;
      core_rst_n_q  <= core_rst_n_d;
      pkt_valid_q   <= pkt_valid_d;
      pkt_chan_q    <= pkt_chan_d;
      pkt_count_q   <= pkt_count_d;
      busy_q        <= busy_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign state       = state_q;
  assign channel_sel = channel_sel_q;
  assign core_en     = core_en_q;
  assign core_rst_n  = core_rst_n_q;
  assign pkt_valid   = pkt_valid_q;
  assign pkt_chan    = pkt_chan_q;
  assign pkt_count   = pkt_count_q;
  assign busy        = busy_q;
  assign cfg_err     = cfg_err_q;

endmodule
